mmio_splitter: RTL and testbench

Parametrised one-to-NSLV MMIO request router for the PVALID/PREADY device bus. Decodes each upstream request against per-slave base/mask windows and forwards it to exactly one downstream device. Returns that device's read data, or an error response for unmapped addresses and for devices that never answer. Sits between a bus master (core LSU or debug bridge) and the MMIO device population.

---
 rtl/mmio_splitter.sv | 135 +++++++++++++
 tb/tb_mmio_splitter.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/mmio_splitter.sv
// mmio_splitter: routes one upstream MMIO request to the matching slave window and returns its response
module mmio_splitter #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int NSLV = 4,
  parameter logic [NSLV*AW-1:0] SLV_BASE = '0,
  parameter logic [NSLV*AW-1:0] SLV_MASK = '0,
  parameter int TIMEOUT = 255,
  parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
  input  logic             PCLK,
  input  logic             PRESETn,
  input  logic             PVALID,
  input  logic [AW-1:0]    PADDR,
  input  logic             PWRITE,
  input  logic [DW-1:0]    PWDATA,
  output logic             PREADY,
  output logic [DW-1:0]    PRDATA,
  output logic             PSLVERR,
  output logic [NSLV-1:0]  M_PVALID,
  output logic [AW-1:0]    M_PADDR,
  output logic             M_PWRITE,
  output logic [DW-1:0]    M_PWDATA,
  input  logic [NSLV-1:0]  M_PREADY,
  input  logic [NSLV*DW-1:0] M_PRDATA
);
  localparam int SW = NSLV > 1 ? $clog2(NSLV) : 1;
  localparam int TW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [DW-1:0] ERR = DW'(ERR_DATA);
  typedef enum logic [1:0] {IDLE, FWD, RESP} state_t;
  state_t state_q, state_d;
  logic [SW-1:0] sel_q, sel_d, hsel;
  logic [TW-1:0] timer_q, timer_d;
  logic [AW-1:0] hmask, maddr_q, maddr_d;
  logic [DW-1:0] prdata_q, prdata_d, mwdata_q, mwdata_d;
  logic [NSLV-1:0] mvalid_q, mvalid_d;
  logic pready_q, pready_d, pslverr_q, pslverr_d, mwrite_q, mwrite_d, hit, fire;
  assign PREADY = pready_q;
  assign PRDATA = prdata_q;
  assign PSLVERR = pslverr_q;
  assign M_PVALID = mvalid_q;
  assign M_PADDR = maddr_q;
  assign M_PWRITE = mwrite_q;
  assign M_PWDATA = mwdata_q;
  assign fire = (TIMEOUT != 0) && (timer_q == TW'(TIMEOUT - 1));
  // Window decode, scanned high-to-low so the lowest matching index wins on overlap
  always_comb begin
    hit = 1'b0;
    hsel = '0;
    hmask = '0;
    for (int i = NSLV - 1; i >= 0; i--)
      if ((PADDR & SLV_MASK[i*AW +: AW]) == (SLV_BASE[i*AW +: AW] & SLV_MASK[i*AW +: AW])) begin
        hit = 1'b1;
        hsel = SW'(i);
        hmask = SLV_MASK[i*AW +: AW];
      end
  end
  // Next-state and registered-output logic: accept in IDLE, wait for slave or timeout in FWD, strobe in RESP
  always_comb begin
    state_d = state_q;
    sel_d = sel_q;
    timer_d = timer_q;
    prdata_d = prdata_q;
    pslverr_d = pslverr_q;
    pready_d = 1'b0;
    mvalid_d = mvalid_q;
    maddr_d = maddr_q;
    mwrite_d = mwrite_q;
    mwdata_d = mwdata_q;
    case (state_q)
      IDLE: if (PVALID) begin
        if (hit) begin
          state_d = FWD;
          sel_d = hsel;
          timer_d = '0;
          mvalid_d = NSLV'(1) << hsel;
          maddr_d = PADDR & ~hmask;
          mwrite_d = PWRITE;
          mwdata_d = PWDATA;
        end else begin
          state_d = RESP;
          prdata_d = ERR;
          pslverr_d = 1'b1;
          pready_d = 1'b1;
        end
      end
      FWD: if (M_PREADY[sel_q]) begin
        state_d = RESP;
        prdata_d = mwrite_q ? '0 : M_PRDATA[sel_q*DW +: DW];
        pslverr_d = 1'b0;
        pready_d = 1'b1;
        mvalid_d = '0;
      end else if (fire) begin
        state_d = RESP;
        prdata_d = ERR;
        pslverr_d = 1'b1;
        pready_d = 1'b1;
        mvalid_d = '0;
      end else begin
        timer_d = &timer_q ? timer_q : timer_q + 1'b1;
      end
      RESP: begin
        state_d = IDLE;
        pslverr_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end
  // State and output registers; asynchronous reset abandons any in-flight request
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q <= IDLE;
      sel_q <= '0;
      timer_q <= '0;
      prdata_q <= '0;
      pslverr_q <= 1'b0;
      pready_q <= 1'b0;
      mvalid_q <= '0;
      maddr_q <= '0;
      mwrite_q <= 1'b0;
      mwdata_q <= '0;
    end else begin
      state_q <= state_d;
      sel_q <= sel_d;
      timer_q <= timer_d;
      prdata_q <= prdata_d;
      pslverr_q <= pslverr_d;
      pready_q <= pready_d;
      mvalid_q <= mvalid_d;
      maddr_q <= maddr_d;
      mwrite_q <= mwrite_d;
      mwdata_q <= mwdata_d;
    end
  end
endmodule

// File: tb/tb_mmio_splitter.sv
// tb_mmio_splitter: scoreboard bench with directed and random requests against a behavioural router model
module tb_mmio_splitter;
  localparam logic [31:0] ERR = 32'hDEAD_BEEF;
  typedef struct {logic [3:0] oh; logic [31:0] addr; logic wr; logic [31:0] wd; int cyc;} fwd_t;
  typedef struct {logic [31:0] d; logic e;} resp_t;
  logic PCLK = 1'b0, PRESETn = 1'b0, PVALID = 1'b0, PWRITE = 1'b0;
  logic [31:0] PADDR = '0, PWDATA = '0, PRDATA, M_PADDR, M_PWDATA;
  logic PREADY, PSLVERR, M_PWRITE;
  logic [3:0] M_PVALID, M_PREADY = '0;
  logic [127:0] M_PRDATA = '0;
  int checks = 0, errors = 0, sl_delay = 0, scnt = 0, fcnt = 0;
  bit force3 = 1'b0, in_fwd = 1'b0, prev_rdy = 1'b0;
  logic [31:0] last_prdata = '0;
  fwd_t fq[$], cur;
  resp_t rq[$];

  mmio_splitter #(
    .AW(32), .DW(32), .NSLV(4),
    .SLV_BASE({32'h2000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000}),
    .SLV_MASK({4{32'hF000_0000}}),
    .TIMEOUT(8), .ERR_DATA(32'hDEAD_BEEF)
  ) dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .PVALID(PVALID), .PADDR(PADDR), .PWRITE(PWRITE),
    .PWDATA(PWDATA), .PREADY(PREADY), .PRDATA(PRDATA), .PSLVERR(PSLVERR),
    .M_PVALID(M_PVALID), .M_PADDR(M_PADDR), .M_PWRITE(M_PWRITE), .M_PWDATA(M_PWDATA),
    .M_PREADY(M_PREADY), .M_PRDATA(M_PRDATA)
  );

  always #5 PCLK = ~PCLK;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Windows are top-nibble bases 0,1,2,2; first match in index order wins
  function automatic int model_sel(input logic [31:0] a);
    int base [4] = '{0, 1, 2, 2};
    for (int i = 0; i < 4; i++) if (int'(a[31:28]) == base[i]) return i;
    return -1;
  endfunction

  // dly: M_PVALID cycle in which the slave answers; 0 = never
  task automatic issue(input logic [31:0] addr, input logic wr, input logic [31:0] wd,
                       input int dly, input logic [31:0] rd, input bit stray3);
    int s, lat, exp_lat;
    bit ok;
    logic [127:0] pr;
    fwd_t f;
    @(negedge PCLK);
    s = model_sel(addr);
    pr = {$urandom, $urandom, $urandom, $urandom};
    if (s >= 0) pr[s*32 +: 32] = rd;
    M_PRDATA = pr;
    sl_delay = dly;
    force3 = stray3;
    PVALID = 1'b1; PADDR = addr; PWRITE = wr; PWDATA = wd;
    if (s < 0) begin
      rq.push_back('{ERR, 1'b1});
      exp_lat = 1;
    end else begin
      ok = dly >= 1 && dly <= 8;
      f.oh = 4'b1 << s; f.addr = addr & 32'h0FFF_FFFF; f.wr = wr; f.wd = wd; f.cyc = ok ? dly : 8;
      fq.push_back(f);
      rq.push_back(ok ? '{wr ? 32'h0 : rd, 1'b0} : '{ERR, 1'b1});
      exp_lat = ok ? dly + 1 : 9;
    end
    lat = 0;
    do begin @(negedge PCLK); lat++; end while (!PREADY && lat < 30);
    chk("latency", lat, exp_lat);
    force3 = 1'b0;
  endtask

  // Behavioural slaves: the selected one answers in its programmed cycle; stray strobes elsewhere
  always @(negedge PCLK) begin
    logic [3:0] stray;
    scnt = (M_PVALID != 0) ? scnt + 1 : 0;
    stray = force3 ? 4'b1000 : ($urandom_range(0, 3) == 0 ? 4'($urandom) : 4'b0);
    M_PREADY = (stray & ~M_PVALID) | ((M_PVALID != 0 && scnt == sl_delay) ? M_PVALID : 4'b0);
  end

  // Forwarding monitor: select, offset, attributes, stability and M_PVALID duration
  always @(negedge PCLK) begin
    if (!PRESETn) in_fwd = 1'b0;
    else if (M_PVALID != 0) begin
      if (!in_fwd) begin
        if (fq.size() == 0) chk("unexpected_fwd", 64'(M_PVALID), 64'h0);
        else begin
          cur = fq.pop_front();
          chk("fwd_sel", 64'(M_PVALID), 64'(cur.oh));
          chk("fwd_addr", 64'(M_PADDR), 64'(cur.addr));
          chk("fwd_write", 64'(M_PWRITE), 64'(cur.wr));
          chk("fwd_wdata", 64'(M_PWDATA), 64'(cur.wd));
        end
        in_fwd = 1'b1;
        fcnt = 1;
      end else begin
        fcnt++;
        chk("fwd_stable", {M_PVALID, M_PWRITE, M_PADDR}, {cur.oh, cur.wr, cur.addr});
      end
    end else if (in_fwd) begin
      chk("fwd_cycles", 64'(fcnt), 64'(cur.cyc));
      in_fwd = 1'b0;
    end
  end

  // Response monitor: pops the scoreboard on every PREADY strobe
  always @(negedge PCLK) begin
    resp_t r;
    if (!PRESETn) prev_rdy = 1'b0;
    else if (PREADY) begin
      if (rq.size() == 0) chk("unexpected_resp", 64'(PRDATA), 64'h0);
      else begin
        r = rq.pop_front();
        chk("resp_data", 64'(PRDATA), 64'(r.d));
        chk("resp_err", 64'(PSLVERR), 64'(r.e));
      end
      last_prdata = PRDATA;
      prev_rdy = 1'b1;
    end else if (prev_rdy) begin
      chk("resp_after", {PSLVERR, PRDATA}, {1'b0, last_prdata});
      prev_rdy = 1'b0;
    end
  end

  initial begin
    int n;
    #3;
    chk("reset_outs", {PREADY, PSLVERR, M_PVALID, M_PWRITE}, 64'h0);
    chk("reset_data", {PRDATA, M_PADDR}, 64'h0);
    chk("reset_wdata", 64'(M_PWDATA), 64'h0);
    @(negedge PCLK); #2 PRESETn = 1'b1;
    issue(32'h1000_0040, 1'b0, 32'h0, 1, 32'hCAFE_0001, 1'b0);
    issue(32'h2000_0004, 1'b1, 32'h55, 3, 32'h0, 1'b0);
    issue(32'h3000_0000, 1'b0, 32'h0, 1, 32'h0, 1'b0);
    issue(32'h0000_0010, 1'b0, 32'h0, 0, 32'h0, 1'b0);
    issue(32'h0000_0020, 1'b0, 32'h0, 8, 32'h1234_5678, 1'b1);
    issue(32'h0000_0030, 1'b0, 32'h0, 9, 32'h0, 1'b0);
    // Reset while forwarding: abandoned with no response
    @(negedge PCLK);
    PVALID = 1'b1; PADDR = 32'h0000_0100; PWRITE = 1'b0; sl_delay = 0;
    fq.push_back('{4'b0001, 32'h100, 1'b0, 32'h0, 8});
    repeat (3) @(negedge PCLK);
    chk("pre_reset_fwd", 64'(M_PVALID), 64'h1);
    #2 PRESETn = 1'b0;
    #1 chk("reset_midfwd", {M_PVALID, PREADY}, 64'h0);
    PVALID = 1'b0;
    @(negedge PCLK); #2 PRESETn = 1'b1;
    issue(32'h1000_0200, 1'b0, 32'h0, 2, 32'h0BAD_F00D, 1'b0);
    for (int i = 0; i < 150; i++) begin
      logic [3:0] nib;
      nib = $urandom_range(0, 7) == 0 ? 4'($urandom_range(4, 15)) : 4'($urandom_range(0, 3));
      issue({nib, 28'($urandom)}, 1'($urandom), $urandom, $urandom_range(0, 10), $urandom, 1'b0);
      if ($urandom_range(0, 2) == 0) begin
        @(negedge PCLK);
        PVALID = 1'b0;
      end
    end
    @(negedge PCLK);
    PVALID = 1'b0;
    n = 0;
    while ((rq.size() != 0 || in_fwd) && n < 50) begin @(negedge PCLK); n++; end
    chk("resp_queue_empty", 64'(rq.size()), 64'h0);
    chk("fwd_queue_empty", 64'(fq.size()), 64'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
